// File: rtl/fifo_port_arbiter.sv
// fifo_port_arbiter: round-robin scheduler sharing one FIFO between NUM_WR writers and one reader.
module fifo_port_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_WR     = 4
) (
   input  logic                         in_clk,
   input  logic                         in_rst_n,
   input  logic                         in_clke,
   input  logic [NUM_WR-1:0]            in_wr_valid,
   input  logic [NUM_WR*DATA_WIDTH-1:0] in_wr_data,
   output logic [NUM_WR-1:0]            out_wr_ready,
   input  logic                         in_rd_req,
   output logic                         out_rd_ready,
   output logic                         out_rd_valid,
   output logic [DATA_WIDTH-1:0]        out_rd_data,
   input  logic                         in_flush,
   output logic                         out_busy,
   output logic                         out_fifo_rst,
   output logic                         out_fifo_en,
   output logic                         out_fifo_read,
   output logic                         out_fifo_write,
   output logic [DATA_WIDTH-1:0]        out_fifo_data,
   input  logic                         in_fifo_empty,
   input  logic                         in_fifo_full,
   input  logic [DATA_WIDTH-1:0]        in_fifo_data
);
   localparam int PW = $clog2(NUM_WR);
   typedef enum logic {ARB, FLUSH} state_t;
   state_t                state_q, state_d;
   logic [PW-1:0]         rr_ptr_q, rr_ptr_d, wr_sel, wr_idx;
   logic                  last_op_q, last_op_d, rd_valid_q, rd_valid_d;
   logic                  act, arb, wr_any, wr_cand, rd_cand, do_wr, do_rd, flush_rd;
   logic [DATA_WIDTH-1:0] wr_word [NUM_WR];
   for (genvar i = 0; i < NUM_WR; i++) begin : g_word
      assign wr_word[i] = in_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
   end
   // Scan downward so the nearest requester at or after rr_ptr is the last one kept.
   always_comb begin
      wr_sel = '0;
      wr_any = 1'b0;
      wr_idx = '0;
      for (int k = NUM_WR - 1; k >= 0; k--) begin
         wr_idx = PW'((int'(rr_ptr_q) + k) % NUM_WR);
         if (in_wr_valid[wr_idx]) begin
            wr_sel = wr_idx;
            wr_any = 1'b1;
         end
      end
   end
   assign act      = in_clke & in_rst_n;
   assign arb      = state_q == ARB;
   assign wr_cand  = wr_any & ~in_fifo_full;
   assign rd_cand  = in_rd_req & ~in_fifo_empty;
   assign do_wr    = act & arb & wr_cand & (~rd_cand | last_op_q);
   assign do_rd    = act & arb & rd_cand & (~wr_cand | ~last_op_q);
   assign flush_rd = act & ~arb & ~in_fifo_empty;
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      last_op_d  = last_op_q;
      rd_valid_d = do_rd;
      state_d    = arb ? (in_flush ? FLUSH : ARB) : (in_fifo_empty ? ARB : FLUSH);
      rr_ptr_d   = !do_wr ? rr_ptr_q : (wr_sel == PW'(NUM_WR - 1) ? '0 : wr_sel + 1'b1);
      last_op_d  = do_wr ? 1'b0 : (do_rd ? 1'b1 : last_op_q);
   end
   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         state_q    <= ARB;
         rr_ptr_q   <= '0;
         last_op_q  <= 1'b1;
         rd_valid_q <= 1'b0;
      end else if (in_clke) begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         last_op_q  <= last_op_d;
         rd_valid_q <= rd_valid_d;
      end
   end
   assign out_wr_ready   = do_wr ? NUM_WR'(1) << wr_sel : '0;
   assign out_rd_ready   = do_rd;
   assign out_rd_valid   = rd_valid_q;
   assign out_rd_data    = in_fifo_data;
   assign out_busy       = state_q == FLUSH;
   assign out_fifo_rst   = ~in_rst_n;
   assign out_fifo_read  = do_rd | flush_rd;
   assign out_fifo_write = do_wr;
   assign out_fifo_en    = do_wr | do_rd | flush_rd;
   assign out_fifo_data  = do_wr ? wr_word[wr_sel] : '0;
endmodule

// File: tb/tb_fifo_port_arbiter.sv
// tb_fifo_port_arbiter: random and directed stimulus against a queue-based reference of the arbiter plus a 32-deep FIFO.
module tb_fifo_port_arbiter;
   localparam int NW = 4;
   localparam int DW = 8;
   localparam int DEPTH = 32;
   logic clk = 1'b0;
   logic rst_n, clke, rd_req, flush;
   logic [NW-1:0]    wr_valid;
   logic [NW*DW-1:0] wr_data;
   logic [NW-1:0]    wr_ready;
   logic             rd_ready, rd_valid, busy, fifo_rst, fifo_en, fifo_read, fifo_write;
   logic [DW-1:0]    rd_data, fifo_data, f_rdata;
   logic             f_empty, f_full;
   logic [DW-1:0]    mem [DEPTH];
   logic [4:0]       wp, rp;
   int               cnt;
   int               n_vec = 0, n_err = 0;
   bit               m_flush, m_last_rd, m_rdv;
   int               m_ptr;
   logic [DW-1:0]    m_rdat;
   logic [DW-1:0]    refq [$];
   bit               count_busy = 0;
   int               busy_cnt = 0;
   always #5 clk = ~clk;
   fifo_port_arbiter #(.DATA_WIDTH(DW), .NUM_WR(NW)) dut (
      .in_clk(clk), .in_rst_n(rst_n), .in_clke(clke),
      .in_wr_valid(wr_valid), .in_wr_data(wr_data), .out_wr_ready(wr_ready),
      .in_rd_req(rd_req), .out_rd_ready(rd_ready), .out_rd_valid(rd_valid), .out_rd_data(rd_data),
      .in_flush(flush), .out_busy(busy), .out_fifo_rst(fifo_rst), .out_fifo_en(fifo_en),
      .out_fifo_read(fifo_read), .out_fifo_write(fifo_write), .out_fifo_data(fifo_data),
      .in_fifo_empty(f_empty), .in_fifo_full(f_full), .in_fifo_data(f_rdata)
   );
   // Environment FIFO: one operation per cycle, registered read data.
   assign f_empty = cnt == 0;
   assign f_full  = cnt == DEPTH;
   always @(posedge clk) begin
      if (fifo_rst) begin
         cnt <= 0;
         wp  <= '0;
         rp  <= '0;
      end else if (clke && fifo_en) begin
         if (fifo_read && cnt > 0) begin
            f_rdata <= mem[rp];
            rp      <= rp + 5'd1;
            cnt     <= cnt - 1;
         end else if (fifo_write && cnt < DEPTH) begin
            mem[wp] <= fifo_data;
            wp      <= wp + 5'd1;
            cnt     <= cnt + 1;
         end
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic step(input logic [NW-1:0] v, input logic [NW*DW-1:0] d, input logic rq,
                       input logic fl, input logic ce, input logic rn);
      int sz, wc;
      bit act, rc, e_rd, e_frd;
      logic [NW-1:0] e_wr;
      logic [DW-1:0] e_fd;
      @(negedge clk);
      wr_valid = v;
      wr_data  = d;
      rd_req   = rq;
      flush    = fl;
      clke     = ce;
      rst_n    = rn;
      #1;
      sz = refq.size();
      act = ce && rn;
      wc = -1;
      rc = 0;
      e_wr = '0;
      e_rd = 0;
      e_frd = 0;
      e_fd = '0;
      if (act && !m_flush) begin
         if (sz < DEPTH)
            for (int k = 0; k < NW; k++)
               if (wc < 0 && v[(m_ptr + k) % NW]) wc = (m_ptr + k) % NW;
         rc = rq && sz > 0;
         if (wc >= 0 && (!rc || m_last_rd)) begin
            e_wr[wc] = 1'b1;
            e_fd = d[wc*DW +: DW];
         end else if (rc) e_rd = 1;
      end
      if (act && m_flush && sz > 0) e_frd = 1;
      chk("wr_ready", 32'(wr_ready), 32'(e_wr));
      chk("rd_ready", 32'(rd_ready), 32'(e_rd));
      chk("fifo_write", 32'(fifo_write), 32'(e_wr != 0));
      chk("fifo_read", 32'(fifo_read), 32'(e_rd | e_frd));
      chk("fifo_en", 32'(fifo_en), 32'((e_wr != 0) | e_rd | e_frd));
      chk("fifo_data", 32'(fifo_data), 32'(e_fd));
      chk("fifo_rst", 32'(fifo_rst), 32'(!rn));
      chk("busy", 32'(busy), 32'(m_flush));
      chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
      if (m_rdv) chk("rd_data", 32'(rd_data), 32'(m_rdat));
      if (count_busy && busy) busy_cnt++;
      @(posedge clk);
      if (!rn) begin
         m_flush = 0;
         m_ptr = 0;
         m_last_rd = 1;
         m_rdv = 0;
         refq.delete();
      end else if (ce) begin
         if (e_wr != 0) begin
            refq.push_back(e_fd);
            m_ptr = (wc + 1) % NW;
            m_last_rd = 0;
         end
         if (e_rd) begin
            m_rdat = refq.pop_front();
            m_last_rd = 1;
         end
         if (e_frd) void'(refq.pop_front());
         m_rdv = e_rd;
         if (!m_flush && fl) m_flush = 1;
         else if (m_flush && sz == 0) m_flush = 0;
      end
   endtask
   initial begin
      rst_n = 1'b0;
      clke = 1'b1;
      wr_valid = '0;
      wr_data = '0;
      rd_req = 1'b0;
      flush = 1'b0;
      repeat (2) @(posedge clk);
      m_flush = 0;
      m_ptr = 0;
      m_last_rd = 1;
      m_rdv = 0;
      // Round-robin with all writers, no reader.
      for (int i = 0; i < 10; i++) step('1, 32'h13121110, 0, 0, 1, 1);
      // Prefill two words, then writer 2 against the reader.
      step('0, '0, 0, 0, 1, 0);
      for (int i = 0; i < 2; i++) step(4'b0001, 32'($urandom), 0, 0, 1, 1);
      for (int i = 0; i < 12; i++) step(4'b0100, 32'($urandom), 1, 0, 1, 1);
      // Fill past full, then drain past empty.
      step('0, '0, 0, 0, 1, 0);
      for (int i = 0; i < 36; i++) step('1, 32'($urandom), 0, 0, 1, 1);
      chk("full", 32'(f_full), 32'd1);
      for (int i = 0; i < 38; i++) step('0, '0, 1, 0, 1, 1);
      chk("empty", 32'(f_empty), 32'd1);
      // Clock enable toggling every other cycle.
      for (int i = 0; i < 40; i++)
         step(NW'($urandom), 32'($urandom), 1'($urandom_range(0, 1)), 0, 1'((i >> 1) & 1), 1);
      // Flush with five words stored.
      step('0, '0, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) step(4'b0010, 32'($urandom), 0, 0, 1, 1);
      step('0, '0, 0, 1, 1, 1);
      count_busy = 1;
      busy_cnt = 0;
      for (int i = 0; i < 8; i++) step('0, '0, 1, 0, 1, 1);
      count_busy = 0;
      chk("flush_len", 32'(busy_cnt), 32'd6);
      chk("flush_empty", 32'(f_empty), 32'd1);
      // Reset in the middle of a flush.
      for (int i = 0; i < 10; i++) step('1, 32'($urandom), 0, 0, 1, 1);
      step('0, '0, 0, 1, 1, 1);
      for (int i = 0; i < 3; i++) step('0, '0, 0, 0, 1, 1);
      step('0, '0, 0, 0, 1, 0);
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_empty", 32'(f_empty), 32'd1);
      for (int i = 0; i < 4; i++) step('1, 32'h44332211, 0, 0, 1, 1);
      // Fully random traffic.
      for (int i = 0; i < 400; i++)
         step(NW'($urandom), 32'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 24) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 79) != 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
